// File: rtl/jtpang_tilemap_if.sv
// Memory-side bus of the tile layer: map RAM scan port plus SDRAM-style ROM request port.
interface jtpang_tilemap_if #(
  parameter int unsigned CW   = 12,
  parameter int unsigned PW   = 7,
  parameter int unsigned ROMW = 18
);
  logic [10:0]        scan_addr;
  logic [CW+PW+1:0]   scan_data;
  logic [ROMW-1:0]    rom_addr;
  logic               rom_cs;
  logic               rom_ok;
  logic [31:0]        rom_data;

  modport master (
    output scan_addr, rom_addr, rom_cs,
    input  scan_data, rom_ok, rom_data
  );

  modport slave (
    input  scan_addr, rom_addr, rom_cs,
    output scan_data, rom_ok, rom_data
  );
endinterface

// File: rtl/jtpang_tilemap.sv
// Scrolling 4bpp tile layer: map scan, one ROM row fetch per tile, per-pixel shifter.
// Fetch runs one tile ahead; a boundary reached before the fetch ends blanks that tile.
module jtpang_tilemap #(
  parameter int unsigned CW   = 12,
  parameter int unsigned PW   = 7,
  parameter int unsigned ROMW = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic [8:0]       h,
  input  logic [7:0]       v,
  input  logic             flip,
  input  logic [8:0]       hscr,
  input  logic [7:0]       vscr,
  jtpang_tilemap_if.master mem,
  output logic [PW+3:0]    pxl,
  output logic             miss
);

  typedef enum logic [1:0] {IDLE, MAP, ROM, DONE} state_t;

  state_t          st, st_nx;
  logic            bnd_c;
  logic [8:0]      sx_c;
  logic [7:0]      sy_c;
  logic [CW-1:0]   map_code_c;
  logic [PW-1:0]   map_pal_c;
  logic            map_hf_c, map_vf_c;
  logic            fetch_c, map_cap_c, rom_cap_c, load_c, blank_c, miss_c;
  logic [PW-1:0]   blank_pal_c;
  logic [3:0]      head_c;
  logic [31:0]     adv_c;

  logic [2:0]      row;
  logic            flip_q;
  logic [PW-1:0]   nxt_pal;
  logic            nxt_hf;
  logic [31:0]     nxt_data;
  logic [31:0]     shift;
  logic [PW-1:0]   cur_pal;
  logic            cur_hf;

  assign bnd_c = pxl_cen && (3'(h[2:0] + hscr[2:0]) == 3'd7);
  assign sx_c  = 9'(h + hscr + 9'd8) ^ {9{flip}};
  assign sy_c  = 8'(v + vscr) ^ {8{flip}};

  assign map_code_c = mem.scan_data[CW-1:0];
  assign map_pal_c  = mem.scan_data[CW+PW-1:CW];
  assign map_hf_c   = mem.scan_data[CW+PW];
  assign map_vf_c   = mem.scan_data[CW+PW+1];

  // A late tile in MAP has not been captured yet, so its palette comes straight from the map
  assign blank_pal_c = (st == MAP) ? map_pal_c : nxt_pal;

  // Planes live one per byte; the head is bit 0 (or bit 7 when mirrored) of every byte
  assign head_c = cur_hf ? {shift[31], shift[23], shift[15], shift[7]}
                         : {shift[24], shift[16], shift[8],  shift[0]};
  assign adv_c  = cur_hf ? ((shift << 1) & 32'hFEFE_FEFE)
                         : ((shift >> 1) & 32'h7F7F_7F7F);

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx     = st;
    fetch_c   = 1'b0;
    map_cap_c = 1'b0;
    rom_cap_c = 1'b0;
    load_c    = 1'b0;
    blank_c   = 1'b0;
    miss_c    = 1'b0;
    case (st)
      IDLE: if (bnd_c) begin
        fetch_c = 1'b1;
        st_nx   = MAP;
      end
      MAP, ROM: if (bnd_c) begin
        miss_c  = 1'b1;
        load_c  = 1'b1;
        blank_c = 1'b1;
        fetch_c = 1'b1;
        st_nx   = MAP;
      end else if (st == MAP) begin
        map_cap_c = 1'b1;
        st_nx     = ROM;
      end else if (mem.rom_ok) begin
        rom_cap_c = 1'b1;
        st_nx     = DONE;
      end
      DONE: if (bnd_c) begin
        load_c  = 1'b1;
        fetch_c = 1'b1;
        st_nx   = MAP;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem.scan_addr <= '0;
      mem.rom_addr  <= '0;
      mem.rom_cs    <= 1'b0;
      miss          <= 1'b0;
      pxl           <= '0;
      row           <= '0;
      flip_q        <= 1'b0;
      nxt_pal       <= '0;
      nxt_hf        <= 1'b0;
      nxt_data      <= '0;
      shift         <= '0;
      cur_pal       <= '0;
      cur_hf        <= 1'b0;
    end else begin
      miss       <= miss_c;
      mem.rom_cs <= (st_nx == ROM);
      if (fetch_c) begin
        mem.scan_addr <= {sy_c[7:3], sx_c[8:3]};
        row           <= sy_c[2:0];
        flip_q        <= flip;
      end
      if (map_cap_c) begin
        nxt_pal      <= map_pal_c;
        nxt_hf       <= map_hf_c ^ flip_q;
        mem.rom_addr <= ROMW'({map_code_c, row ^ {3{map_vf_c ^ flip_q}}});
      end
      if (rom_cap_c) nxt_data <= mem.rom_data;
      if (pxl_cen) pxl <= {cur_pal, head_c};
      if (load_c) begin
        shift   <= blank_c ? 32'd0 : nxt_data;
        cur_pal <= blank_c ? blank_pal_c : nxt_pal;
        cur_hf  <= nxt_hf;
      end else if (pxl_cen) begin
        shift <= adv_c;
      end
    end
  end

endmodule
